// File: rtl/cmd_queue.sv
// In-order command FIFO with first-word-fall-through head, occupancy flags and sticky error flags.
// Flags decode from the registered count only, so i_wr/i_rd never reach them combinationally.
package cmd_queue_pkg;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] tag;
  } cmd_t;
endpackage

module cmd_queue #(
  parameter int CMD_W    = $bits(cmd_queue_pkg::cmd_t),
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_wr,
  input  logic [CMD_W-1:0]         i_cmd,
  output logic                     o_full,
  output logic                     o_afull,
  input  logic                     i_rd,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf,
  output logic                     o_udf,
  input  logic                     i_clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF  = (AW+1)'(AFULL_TH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             ovf;
  logic             udf;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_set;
  logic             udf_set;

  assign o_full  = (cnt == CNT_MAX);
  assign o_empty = (cnt == '0);
  assign o_afull = (cnt >= CNT_AF);
  assign o_count = cnt;
  assign o_ovf   = ovf;
  assign o_udf   = udf;

  // A pop frees the slot in the same cycle, so a full queue may still take a write.
  assign rd_ok   = i_rd && !o_empty;
  assign wr_ok   = i_wr && (!o_full || rd_ok);
  assign ovf_set = i_wr && o_full && !i_rd;
  assign udf_set = i_rd && o_empty;

  assign o_cmd = o_empty ? '0 : mem[rp];

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wp] <= i_cmd;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      if (wr_ok && !rd_ok)      cnt <= cnt + (AW+1)'(1);
      else if (rd_ok && !wr_ok) cnt <= cnt - (AW+1)'(1);
    end
  end

  // Set has priority so an error coinciding with a clear is never lost.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)        ovf <= 1'b1;
      else if (i_clr_err) ovf <= 1'b0;
      if (udf_set)        udf <= 1'b1;
      else if (i_clr_err) udf <= 1'b0;
    end
  end

  a_cnt_bound: assert property (@(posedge i_clk) disable iff (!i_rstn) cnt <= CNT_MAX);
  a_no_drop_on_pop: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (i_wr && i_rd && o_full) |-> wr_ok);

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue: stimulus pushes expected heads into a queue, a negedge monitor checks every pop.
module tb_cmd_queue;
  localparam int W     = $bits(cmd_queue_pkg::cmd_t);
  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  wr;
  logic [W-1:0]          cmd;
  logic                  full;
  logic                  afull;
  logic                  rd;
  logic [W-1:0]          head;
  logic                  empty;
  logic [$clog2(DEPTH):0] count;
  logic                  ovf;
  logic                  udf;
  logic                  clr_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  cmd_queue #(.CMD_W(W), .DEPTH(DEPTH), .AFULL_TH(DEPTH-2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_cmd(cmd), .o_full(full), .o_afull(afull),
    .i_rd(rd), .o_cmd(head), .o_empty(empty), .o_count(count), .o_ovf(ovf), .o_udf(udf),
    .i_clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop is accepted whenever rd is high on a non-empty queue.
  always @(negedge clk) begin
    if (rstn && rd && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected nothing", head);
      end else begin
        if (head != exp_q[0]) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", head, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic w, input logic [W-1:0] c, input logic r, input logic cl);
    wr = w; cmd = c; rd = r; clr_err = cl;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] c);
    exp_q.push_back(c);
    cyc(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"},  int'(full),  0);
    chk({tag, "_afull"}, int'(afull), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_cmd"},   int'(head),  0);
    chk({tag, "_ovf"},   int'(ovf),   0);
    chk({tag, "_udf"},   int'(udf),   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, mcnt, ncyc;
    logic dw, dr;

    rstn = 1'b0; wr = 1'b0; cmd = '0; rd = 1'b0; clr_err = 1'b0;
    #3;
    chk_reset_state("reset");
    #9 rstn = 1'b1;
    @(posedge clk); #1;

    // Fill to full, watching afull/full thresholds.
    for (int i = 1; i <= DEPTH; i++) begin
      push(W'(i));
      chk("fill_afull", int'(afull), (i >= 14) ? 1 : 0);
      chk("fill_full",  int'(full),  (i == 16) ? 1 : 0);
    end
    chk("fill_count", int'(count), 16);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("drain_empty", int'(empty), 1);
    chk("drain_cmd",   int'(head),  0);
    chk("drain_udf",   int'(udf),   0);

    // Underflow coinciding with clear: set wins.
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("udf_set_wins", int'(udf), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("udf_clear", int'(udf), 0);

    // Overflow: dropped write must not disturb contents.
    for (int i = 0; i < DEPTH; i++) push(W'(8'h21 + i));
    cyc(1'b1, W'(8'hAA), 1'b0, 1'b0);
    chk("ovf_set",   int'(ovf),   1);
    chk("ovf_count", int'(count), 16);
    chk("ovf_head",  int'(head),  8'h21);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clear", int'(ovf), 0);

    // Push and pop together at full: 0x55 lands behind the remaining 15.
    exp_q.push_back(W'(8'h55));
    cyc(1'b1, W'(8'h55), 1'b1, 1'b0);
    chk("rw_full_count", int'(count), 16);
    chk("rw_full_ovf",   int'(ovf),   0);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("rw_full_drained", int'(empty), 1);

    // Push and pop together at empty: pop ignored, udf sets, entry stored.
    exp_q.push_back(W'(8'h77));
    cyc(1'b1, W'(8'h77), 1'b1, 1'b0);
    chk("rw_empty_udf",   int'(udf),   1);
    chk("rw_empty_count", int'(count), 1);
    chk("rw_empty_cmd",   int'(head),  8'h77);
    pop();
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("rw_empty_clr", int'(udf), 0);

    // Wrap-around stream with random backpressure, occupancy held in 1..15.
    sent = 0; mcnt = 0; ncyc = 0;
    while ((sent < 40 || mcnt > 0) && ncyc < 2000) begin
      dw = (sent < 40) && (mcnt < 15) && (mcnt < 2 || $urandom_range(0, 1) == 1);
      dr = (mcnt > 0) && (sent == 40 || (mcnt > 1 && $urandom_range(0, 1) == 1));
      if (dw) exp_q.push_back(W'(sent));
      cyc(dw, W'(sent), dr, 1'b0);
      if (dw) sent++;
      mcnt = mcnt + int'(dw) - int'(dr);
      chk("wrap_count", int'(count), mcnt);
      ncyc++;
    end
    chk("wrap_done", int'(sent == 40 && mcnt == 0), 1);

    // Asynchronous reset with 5 entries queued.
    for (int i = 0; i < 5; i++) push(W'(8'h41 + i));
    chk("pre_rst_count", int'(count), 5);
    #2 rstn = 1'b0;
    #1;
    chk_reset_state("midrst");
    exp_q.delete();
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    push(W'(8'h33));
    chk("post_rst_head",  int'(head),  8'h33);
    chk("post_rst_empty", int'(empty), 0);
    chk("post_rst_count", int'(count), 1);
    pop();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_queue.md
# cmd_queue

Command FIFO between the host/command source and the issuer, completing the top-level command path (queue_cmd / queue_empty / issuer_rd_queue). It buffers `cmd_t` words in order and presents the head entry first-word-fall-through, so the issuer samples `o_cmd` and pops with `i_rd` in the same cycle. It also tracks occupancy, raises an almost-full warning and records sticky overflow and underflow errors.

## Interface
- `CMD_W`, default `$bits(cmd_t)`: command word width.
- `DEPTH`, default 16: number of entries. Must be a power of two and ≥ 2.
- `AFULL_TH`, default `DEPTH-2`: `o_afull` asserts when count ≥ AFULL_TH.

- `i_clk`  in  1  clock.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_wr`  in  1  push `i_cmd` this cycle.
- `i_cmd`  in  CMD_W  command to push.
- `o_full`  out  1  count == DEPTH.
- `o_afull`  out  1  count ≥ AFULL_TH.
- `i_rd`  in  1  pop the head entry; driven by the issuer's `o_rd_queue`.
- `o_cmd`  out  CMD_W  head entry; all-zero while empty.
- `o_empty`  out  1  count == 0; feeds the issuer's `i_empty_queue`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_ovf`  out  1  sticky flag: a write was dropped.
- `o_udf`  out  1  sticky flag: a read was issued while empty.
- `i_clr_err`  in  1  synchronous clear of `o_ovf` and `o_udf`.

## Operation
- **Storage:** DEPTH × CMD_W register array, with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate counter `cnt`.
- **Write accept:** `wr_ok = i_wr && (!o_full || rd_ok)`. When full, a write in the same cycle as a pop is accepted.
- **Read accept:** `rd_ok = i_rd && !o_empty`. There is no empty bypass: a read while empty is ignored even if a write occurs in the same cycle.
- **Count update:**
  - `cnt` increments on `wr_ok && !rd_ok`.
  - `cnt` decrements on `rd_ok && !wr_ok`.
  - `cnt` is unchanged when both or neither occur.
- **Output:** `o_cmd = o_empty ? '0 : mem[rp]`. This is a combinational read of the registered array.
- **Flags:** `o_full`, `o_empty`, `o_afull` and `o_count` are decoded from registered `cnt`, so they carry no combinational path from `i_wr` or `i_rd`.
- **Errors:**
  - `o_ovf` sets on `i_wr && o_full && !i_rd`.
  - `o_udf` sets on `i_rd && o_empty`.
  - `i_clr_err` clears both flags. If a set condition and the clear occur in the same cycle, set wins.
- **Ordering:** strict FIFO. Dropped writes do not corrupt stored entries.

## Timing
- **Reset (asynchronous, all outputs immediate):**
  - `wp`, `rp` and `cnt` = 0.
  - `o_empty` = 1.
  - `o_full`, `o_afull`, `o_ovf` and `o_udf` = 0.
  - `o_count` = 0 and `o_cmd` = 0.
  - Array contents are not reset.
- **Write latency:** a write accepted at edge N is visible on `o_cmd`/`o_empty` after edge N, i.e. one cycle of latency when the FIFO was empty.
- **Pop:** a pop at edge N advances `o_cmd` to the next entry, or to 0 if that pop empties the FIFO, after edge N.
- **Issuer contract:** the issuer samples `o_cmd` in the same cycle it asserts `i_rd`.
- **Reset mid-operation:** all queued commands are discarded. The first write after `i_rstn` rises is the next head.
- **Simultaneous read and write at the extremes:**
  - At full: count stays DEPTH and the new entry goes to the slot just vacated.
  - At empty: count goes to 1 and `o_udf` sets.

## Test plan
- **Fill to full:** reset, then push 0x01..0x10 with DEPTH=16.
  - `o_afull` rises after the 14th push.
  - `o_full` rises after the 16th push and `o_count` = 16.
  - Pop 16 times and check the head values are 0x01..0x10 in order, then `o_empty` = 1 and `o_cmd` = 0.
- **Overflow:** when full, push 0xAA with `i_rd` = 0.
  - `o_ovf` = 1 and `o_count` stays 16.
  - Drain the FIFO and check 0xAA never appears.
  - Assert `i_clr_err` and check `o_ovf` = 0.
- **Read and write while full:** when full, assert push 0x55 and pop together for 1 cycle.
  - `o_count` stays 16 and `o_ovf` = 0.
  - 0x55 emerges last after the 15 remaining entries.
- **Read and write while empty:** when empty, assert push 0x77 and pop together.
  - `o_udf` = 1 and `o_count` = 1.
  - `o_cmd` = 0x77 on the next cycle.
- **Wrap-around:** stream 40 commands with random push/pop backpressure, keeping count between 1 and 15. The output sequence must equal the input sequence 0..39.
- **Reset mid-operation:**
  - With 5 entries stored, pulse `i_rstn` low asynchronously between clock edges.
  - All outputs take their reset values immediately.
  - A subsequent push of 0x33 appears as head one cycle later.
